bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 45 ++++
 rtl/bus_arbiter_watchdog.sv | 50 +++++
 rtl/bus_arbiter.sv | 63 ++++++
 tb/tb_bus_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared bus header: owner encodings, active-low enable levels and the
// round-robin scan helper used by the arbiter.
package bus_arbiter_pkg;

    localparam int unsigned BUS_OWNER_WIDTH = 2;
    localparam int unsigned BUS_MASTERS     = 4;
    localparam int unsigned BUS_WDT_WIDTH   = 8;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [BUS_OWNER_WIDTH-1:0] {
        BUS_OWNER_MASTER_0 = 2'd0,
        BUS_OWNER_MASTER_1 = 2'd1,
        BUS_OWNER_MASTER_2 = 2'd2,
        BUS_OWNER_MASTER_3 = 2'd3
    } bus_owner_e;

    typedef enum logic {
        WDT_IDLE,
        WDT_PENDING
    } wdt_state_e;

    // First requester after the current owner (owner+1 .. owner+3, wrapping);
    // the owner itself is kept when nobody else is asking.
    function automatic bus_owner_e bus_scan_next(
        input bus_owner_e                   owner,
        input logic [BUS_MASTERS-1:0]       req_
    );
        bus_owner_e                  result;
        logic [BUS_OWNER_WIDTH-1:0]  cand;
        logic                        found;
        result = owner;
        found  = 1'b0;
        for (int unsigned i = 1; i < BUS_MASTERS; i++) begin
            cand = owner + BUS_OWNER_WIDTH'(i);
            if (!found && req_[cand] == ENABLE_) begin
                result = bus_owner_e'(cand);
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// Bus watchdog: tracks an unanswered address strobe and aborts the access
// once ready has stayed away for TIMEOUT_CYCLES cycles.
module bus_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_,
    input  logic m_as_,
    input  logic m_rdy_,
    input  logic owner_change,
    output logic bus_timeout
);

    localparam logic [BUS_WDT_WIDTH-1:0] LIMIT = BUS_WDT_WIDTH'(TIMEOUT_CYCLES);

    wdt_state_e               state_q, state_d;
    logic [BUS_WDT_WIDTH-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= WDT_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Ready in the compare cycle takes precedence over the abort.
    always_comb begin
        state_d     = state_q;
        count_d     = '0;
        bus_timeout = (state_q == WDT_PENDING) && (m_rdy_ == DISABLE_) && (count_q == LIMIT);
        if (owner_change || bus_timeout) begin
            state_d = WDT_IDLE;
        end else if (m_rdy_ == ENABLE_) begin
            state_d = WDT_IDLE;
        end else begin
            if (m_as_ == ENABLE_) begin
                state_d = WDT_PENDING;
            end
            if (state_q == WDT_PENDING) begin
                count_d = count_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with non-preemptive, parked grants and
// a watchdog that forces the bus onward when an access stalls.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_,
    input  logic m0_req_,
    input  logic m1_req_,
    input  logic m2_req_,
    input  logic m3_req_,
    output logic m0_grnt_,
    output logic m1_grnt_,
    output logic m2_grnt_,
    output logic m3_grnt_,
    input  logic m_as_,
    input  logic m_rdy_,
    output logic bus_timeout
);

    bus_owner_e             owner, owner_next;
    logic [BUS_MASTERS-1:0] req_;
    logic                   owner_change;

    assign req_ = {m3_req_, m2_req_, m1_req_, m0_req_};

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            owner <= BUS_OWNER_MASTER_0;
        end else begin
            owner <= owner_next;
        end
    end

    // A timeout advances the scan even while the owner still holds its request.
    always_comb begin
        owner_next = owner;
        if (req_[owner] == DISABLE_ || bus_timeout) begin
            owner_next = bus_scan_next(owner, req_);
        end
    end

    assign owner_change = (owner_next != owner);

    assign m0_grnt_ = (owner == BUS_OWNER_MASTER_0) ? ENABLE_ : DISABLE_;
    assign m1_grnt_ = (owner == BUS_OWNER_MASTER_1) ? ENABLE_ : DISABLE_;
    assign m2_grnt_ = (owner == BUS_OWNER_MASTER_2) ? ENABLE_ : DISABLE_;
    assign m3_grnt_ = (owner == BUS_OWNER_MASTER_3) ? ENABLE_ : DISABLE_;

    bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk          (clk),
        .reset_       (reset_),
        .m_as_        (m_as_),
        .m_rdy_       (m_rdy_),
        .owner_change (owner_change),
        .bus_timeout  (bus_timeout)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a driver feeds directed and random cycles
// through a reference model; a negedge monitor compares every cycle.
module tb_bus_arbiter;

    localparam int TO = 4;

    logic clk;
    logic reset_;
    logic m0_req_, m1_req_, m2_req_, m3_req_;
    logic m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic m_as_, m_rdy_;
    logic bus_timeout;

    bus_arbiter #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset_      (reset_),
        .m0_req_     (m0_req_),
        .m1_req_     (m1_req_),
        .m2_req_     (m2_req_),
        .m3_req_     (m3_req_),
        .m0_grnt_    (m0_grnt_),
        .m1_grnt_    (m1_grnt_),
        .m2_grnt_    (m2_grnt_),
        .m3_grnt_    (m3_grnt_),
        .m_as_       (m_as_),
        .m_rdy_      (m_rdy_),
        .bus_timeout (bus_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] grnt;
        logic       to;
        string      ph;
    } exp_t;

    exp_t q[$];
    int   tests   = 0;
    int   fails   = 0;
    int   seen_to = 0;

    // Reference model: the outstanding strobe is remembered by the cycle
    // number it was accepted in; its age decides the abort.
    int m_owner  = 0;
    int m_strobe = -1;
    int cyc      = 0;

    task automatic model_step(input logic [3:0] req, input logic as_n, input logic rdy_n,
                              input logic rst_n, input string ph, output exp_t e);
        int nxt;
        bit to;
        e.ph = ph;
        if (!rst_n) begin
            e.grnt   = 4'b1110;
            e.to     = 1'b0;
            m_owner  = 0;
            m_strobe = -1;
        end else begin
            e.grnt = 4'b1111;
            e.grnt[m_owner] = 1'b0;
            to = (m_strobe >= 0) && rdy_n && (cyc - m_strobe - 1 == TO);
            e.to = to;
            nxt = m_owner;
            if (req[m_owner] || to)
                for (int k = 3; k >= 1; k--)
                    if (!req[(m_owner + k) % 4]) nxt = (m_owner + k) % 4;
            if (nxt != m_owner || to || !rdy_n) m_strobe = -1;
            else if (!as_n && m_strobe < 0) m_strobe = cyc;
            m_owner = nxt;
        end
        cyc++;
    endtask

    task automatic cycle(input logic [3:0] req, input logic as_n, input logic rdy_n,
                         input logic rst_n, input string ph);
        exp_t e;
        @(posedge clk);
        #1;
        {m3_req_, m2_req_, m1_req_, m0_req_} = req;
        m_as_  = as_n;
        m_rdy_ = rdy_n;
        reset_ = rst_n;
        model_step(req, as_n, rdy_n, rst_n, ph, e);
        q.push_back(e);
        if (!rst_n) begin
            #1;
            tests++;
            if ({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} !== 4'b1110 || bus_timeout !== 1'b0) begin
                fails++;
                $display("FAIL async_reset_%s: grnt_=%b timeout=%b, expected grnt_=1110 timeout=0",
                         ph, {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}, bus_timeout);
            end
        end
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    task automatic check_count(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if ({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} !== e.grnt || bus_timeout !== e.to) begin
                fails++;
                $display("FAIL %s: grnt_=%b timeout=%b, expected grnt_=%b timeout=%b",
                         e.ph, {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}, bus_timeout, e.grnt, e.to);
            end
            if (bus_timeout === 1'b1) seen_to++;
        end
    end

    initial begin
        int         base;
        logic [3:0] req;
        reset_ = 1'b0;
        {m3_req_, m2_req_, m1_req_, m0_req_} = 4'b1111;
        m_as_  = 1'b1;
        m_rdy_ = 1'b1;
        #1;
        tests++;
        if ({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} !== 4'b1110 || bus_timeout !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: grnt_=%b timeout=%b, expected grnt_=1110 timeout=0",
                     {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}, bus_timeout);
        end

        cycle(4'b1111, 1, 1, 0, "in_reset");
        cycle(4'b1111, 1, 1, 0, "in_reset");
        for (int i = 0; i < 20; i++) cycle(4'b1111, 1, 1, 1, "idle_after_reset");

        // Round-robin handover 0 -> 1 -> 3 -> 0.
        for (int i = 0; i < 3; i++) cycle(4'b1110, 1, 1, 1, "m0_holds");
        for (int i = 0; i < 3; i++) cycle(4'b0101, 1, 1, 1, "hand_to_m1");
        for (int i = 0; i < 3; i++) cycle(4'b0111, 1, 1, 1, "hand_to_m3");
        for (int i = 0; i < 3; i++) cycle(4'b1110, 1, 1, 1, "wrap_to_m0");

        // No preemption of a holding owner.
        for (int i = 0; i < 2; i++) cycle(4'b1011, 1, 1, 1, "hand_to_m2");
        for (int i = 0; i < 100; i++) cycle(4'b0000, 1, 1, 1, "m2_no_preempt");

        // Stalled access by owner 1 aborts and moves on to m2.
        for (int i = 0; i < 2; i++) cycle(4'b1101, 1, 1, 1, "hand_to_m1b");
        drain();
        base = seen_to;
        cycle(4'b1001, 0, 1, 1, "stall_strobe");
        for (int i = 0; i < 10; i++) cycle(4'b1001, 1, 1, 1, "stall_wait");
        drain();
        check_count("timeout_once", seen_to - base, 1);

        // Ready on the compare cycle, then a zero-wait access: no abort.
        base = seen_to;
        cycle(4'b1011, 0, 1, 1, "late_ready_strobe");
        for (int i = 0; i < 4; i++) cycle(4'b1011, 1, 1, 1, "late_ready_wait");
        cycle(4'b1011, 1, 0, 1, "late_ready_hit");
        cycle(4'b1011, 0, 0, 1, "zero_wait");
        for (int i = 0; i < 10; i++) cycle(4'b1011, 1, 1, 1, "zero_wait_idle");
        drain();
        check_count("no_timeout", seen_to - base, 0);

        // Reset during a wait with owner 3.
        base = seen_to;
        for (int i = 0; i < 2; i++) cycle(4'b0111, 1, 1, 1, "hand_to_m3b");
        cycle(4'b0111, 0, 1, 1, "m3_strobe");
        for (int i = 0; i < 3; i++) cycle(4'b0111, 1, 1, 1, "m3_wait");
        cycle(4'b0111, 1, 1, 0, "mid_wait_reset");
        for (int i = 0; i < 10; i++) cycle(4'b0111, 1, 1, 1, "after_reset");
        drain();
        check_count("reset_no_timeout", seen_to - base, 0);

        // Randomised traffic.
        req = 4'b1111;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            cycle(req, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 199) != 0), "random");
        end
        drain();
        check_count("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
